// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam int          DATA_BITS        = 8;
  localparam logic [31:0] MIN_DIV          = 32'd2;
  localparam logic [31:0] UART_DEFAULT_DIV = 32'd106;

  // A divisor of 0 or 1 cannot produce a distinct bit period; floor it.
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with occupancy count; a push while full is refused even if a pop happens the same cycle.
module uart_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by plain overflow.
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a byte FIFO, with a runtime-programmable baud divisor.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int          DEPTH       = 8,
  parameter int unsigned DEFAULT_DIV = UART_DEFAULT_DIV
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   div_we,
  input  logic [31:0]            div_di,
  output logic [31:0]            div_do,
  input  logic [7:0]             tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic                   ser_tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  uart_state_t state, state_d;
  logic [31:0] div_q;
  logic [31:0] frame_div, fdiv_d;
  logic [31:0] cyc_cnt, cyc_d;
  logic [2:0]  bit_cnt, bit_d;
  logic [7:0]  shreg, sh_d;
  logic        ser_q, ser_d;
  logic        load, bit_end;
  logic        fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_data;

  uart_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_valid),
    .push_data (tx_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign div_do   = div_q;
  assign tx_ready = ~fifo_full;
  assign ser_tx   = ser_q;
  assign busy     = (state != IDLE) | ~fifo_empty;

  always_ff @(posedge clk) begin
    if (reset)       div_q <= 32'(DEFAULT_DIV);
    else if (div_we) div_q <= clamp_div(div_di);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      frame_div <= 32'(DEFAULT_DIV);
      cyc_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      ser_q     <= 1'b1;
    end else begin
      state     <= state_d;
      frame_div <= fdiv_d;
      cyc_cnt   <= cyc_d;
      bit_cnt   <= bit_d;
      shreg     <= sh_d;
      ser_q     <= ser_d;
    end
  end

  // Each line level is the registered ser_q, so the next level is decided
  // one cycle ahead at the end of the current bit period.
  always_comb begin
    state_d  = state;
    fdiv_d   = frame_div;
    cyc_d    = cyc_cnt;
    bit_d    = bit_cnt;
    sh_d     = shreg;
    ser_d    = ser_q;
    load     = 1'b0;
    fifo_pop = 1'b0;
    bit_end  = (cyc_cnt == frame_div - 32'd1);

    case (state)
      IDLE: load = ~fifo_empty;
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cyc_d   = '0;
          bit_d   = '0;
          ser_d   = shreg[0];
          sh_d    = shreg >> 1;
        end else begin
          cyc_d = cyc_cnt + 32'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cyc_d = '0;
          if (bit_cnt == 3'(DATA_BITS - 1)) begin
            state_d = STOP;
            ser_d   = 1'b1;
          end else begin
            bit_d = bit_cnt + 3'd1;
            ser_d = shreg[0];
            sh_d  = shreg >> 1;
          end
        end else begin
          cyc_d = cyc_cnt + 32'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cyc_d   = '0;
          state_d = IDLE;
          load    = ~fifo_empty;
        end else begin
          cyc_d = cyc_cnt + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame load: pop, drop the line for the start bit and freeze the divisor
    // so a mid-frame divisor write only affects later frames.
    if (load) begin
      fifo_pop = 1'b1;
      state_d  = START;
      cyc_d    = '0;
      bit_d    = '0;
      sh_d     = fifo_data;
      fdiv_d   = div_q;
      ser_d    = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench: stimulus queues expected bytes and checks; a negedge monitor decodes the line and scores.
module tb_uart_tx_fifo;

  localparam int DEPTH   = 8;
  localparam int DEF_DIV = 106;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        div_we = 1'b0;
  logic [31:0] div_di = '0;
  logic [7:0]  tx_data = '0;
  logic        tx_valid = 1'b0;
  logic [31:0] div_do;
  logic        tx_ready, ser_tx, busy;
  logic [3:0]  level;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH), .DEFAULT_DIV(DEF_DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .div_we   (div_we),
    .div_di   (div_di),
    .div_do   (div_do),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .ser_tx   (ser_tx),
    .busy     (busy),
    .level    (level)
  );

  typedef struct {
    string       name;
    logic [31:0] got;
    logic [31:0] exp;
  } chk_t;

  chk_t       chk_q[$];
  logic [7:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         model_div = DEF_DIV;
  int         cyc_n = 0;

  always @(posedge clk) cyc_n++;

  // Monitor: scores queued checks and decodes every frame cycle-by-cycle.
  logic       mon_active = 1'b0;
  logic       rogue = 1'b0;
  logic       bad = 1'b0;
  logic [7:0] cur = '0;
  int         cur_div = DEF_DIV;
  int         mcyc = 0;

  always @(negedge clk) begin
    chk_t c;
    int   bidx;
    logic expb;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      checks++;
      if (c.got !== c.exp) begin
        errors++;
        $display("FAIL %s: got %0d, expected %0d", c.name, c.got, c.exp);
      end
    end
    if (reset) begin
      mon_active = 1'b0;
    end else begin
      if (!mon_active && ser_tx === 1'b0) begin
        mon_active = 1'b1;
        mcyc       = 0;
        bad        = 1'b0;
        cur_div    = model_div;
        if (exp_q.size() == 0) begin
          rogue = 1'b1;
          checks++;
          errors++;
          $display("FAIL unexpected_frame: line low at cycle %0d with no byte expected", cyc_n);
        end else begin
          rogue = 1'b0;
          cur   = exp_q.pop_front();
        end
      end
      if (mon_active) begin
        bidx = mcyc / cur_div;
        expb = (bidx == 0) ? 1'b0 : (bidx == 9) ? 1'b1 : cur[bidx-1];
        if (!rogue && ser_tx !== expb) bad = 1'b1;
        if (!rogue && (mcyc % cur_div) == cur_div - 1) begin
          checks++;
          if (bad) begin
            errors++;
            $display("FAIL frame_bit: byte 0x%02h slot %0d (div %0d) line wrong, expected %0d", cur, bidx, cur_div, expb);
          end
          bad = 1'b0;
        end
        mcyc++;
        if (mcyc == 10 * cur_div) mon_active = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] g, input logic [31:0] e);
    chk_t c;
    c.name = n;
    c.got  = g;
    c.exp  = e;
    chk_q.push_back(c);
  endtask

  task automatic push_byte(input logic [7:0] b, output int w);
    w        = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && w < 5000) begin
      tick();
      w++;
    end
    if (w >= 5000) begin
      chk("push_timeout", 32'd1, 32'd0);
    end else begin
      tick();
      exp_q.push_back(b);
    end
    tx_valid = 1'b0;
  endtask

  task automatic write_div(input logic [31:0] v);
    div_di    = v;
    div_we    = 1'b1;
    tick();
    div_we    = 1'b0;
    model_div = (v < 2) ? 2 : int'(v);
  endtask

  task automatic wait_idle(input int limit);
    int w = 0;
    while ((busy || mon_active) && w < limit) begin
      tick();
      w++;
    end
    if (w >= limit) chk("idle_timeout", 32'd1, 32'd0);
    chk("bytes_left", 32'(exp_q.size()), 32'd0);
  endtask

  // Called right after the push edge of a byte into an idle block.
  task automatic measure_frame(input string n, input int exp_cycles);
    int k = 0;
    chk("latency_not_early", 32'(ser_tx), 32'd1);
    tick();
    chk("latency_ser_low", 32'(ser_tx), 32'd0);
    while (busy && k < 5000) begin
      tick();
      k++;
    end
    chk(n, 32'(k), 32'(exp_cycles));
  endtask

  initial begin
    int w;
    int t0;

    // Reset state
    tx_valid = 1'b1;
    div_we   = 1'b1;
    div_di   = 32'd7;
    tick();
    tick();
    tx_valid = 1'b0;
    div_we   = 1'b0;
    chk("rst_ser_tx", 32'(ser_tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_div_do", div_do, 32'(DEF_DIV));
    reset = 1'b0;
    tick();

    // 0x55 at the default divisor: 10 bits of 106 cycles
    push_byte(8'h55, w);
    measure_frame("busy_fall_0x55", 1060);
    wait_idle(3000);

    // Nine back-to-back bytes fill the FIFO, a tenth stalls until a pop
    write_div(32'd8);
    push_byte(8'h00, w);
    t0 = cyc_n;
    for (int i = 1; i < 9; i++) push_byte(8'(i), w);
    chk("fill_level", 32'(level), 32'd8);
    chk("fill_tx_ready", 32'(tx_ready), 32'd0);
    push_byte(8'h09, w);
    chk("stall_cycles", 32'(w), 32'd73);
    while (busy && cyc_n < t0 + 2000) tick();
    chk("burst_total_cycles", 32'(cyc_n - t0), 32'd801);
    wait_idle(3000);

    // Divisor below the minimum is floored to 2
    write_div(32'd1);
    chk("div_clamped", div_do, 32'd2);
    push_byte(8'hA3, w);
    measure_frame("busy_fall_0xA3", 20);
    wait_idle(200);

    // Divisor change during bit 3 only affects the next frame
    write_div(32'd106);
    push_byte(8'h3C, w);
    t0 = cyc_n;
    push_byte(8'h5A, w);
    repeat (450) tick();
    write_div(32'd20);
    chk("div_mid_frame", div_do, 32'd20);
    while (busy && cyc_n < t0 + 3000) tick();
    chk("mixed_div_total", 32'(cyc_n - t0), 32'd1261);
    wait_idle(3000);

    // Push offered while full, on the exact pop edge, is refused
    write_div(32'd4);
    push_byte(8'hC1, w);
    t0 = cyc_n;
    for (int i = 0; i < 8; i++) push_byte(8'hD0 + 8'(i), w);
    chk("full_level", 32'(level), 32'd8);
    chk("full_tx_ready", 32'(tx_ready), 32'd0);
    while (cyc_n < t0 + 40) tick();
    tx_data  = 8'hEE;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    chk("refused_level", 32'(level), 32'(DEPTH - 1));
    chk("refused_tx_ready", 32'(tx_ready), 32'd1);
    wait_idle(1000);

    // One-cycle reset mid-DATA with three bytes queued
    write_div(32'd8);
    push_byte(8'h11, w);
    push_byte(8'h22, w);
    push_byte(8'h33, w);
    push_byte(8'h44, w);
    chk("queued_level", 32'(level), 32'd3);
    repeat (30) tick();
    reset    = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h99;
    div_we   = 1'b1;
    div_di   = 32'd50;
    exp_q.delete();
    tick();
    reset    = 1'b0;
    tx_valid = 1'b0;
    div_we   = 1'b0;
    model_div = DEF_DIV;
    chk("abort_ser_tx", 32'(ser_tx), 32'd1);
    chk("abort_level", 32'(level), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_div_do", div_do, 32'(DEF_DIV));
    repeat (300) tick();
    chk("post_abort_ser_tx", 32'(ser_tx), 32'd1);
    chk("post_abort_busy", 32'(busy), 32'd0);
    chk("post_abort_level", 32'(level), 32'd0);

    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
